putbits_packer: RTL
===================

# putbits_packer

MSB-first bitstream writer for the MPEG encoder path, the write-side counterpart of the bit-buffer refill logic used by the decoder. It accepts variable-length codes (value plus bit count, 0–32 bits) over a valid/ready handshake and packs them into a 40-bit accumulator. It emits packed bytes in stream order on a byte-wide valid/ready output. A flush request zero-pads to the next byte boundary, drains the accumulator and reports completion; this is used for start-code alignment and end of sequence.

## Interface
- No parameters. The accumulator is fixed at 40 bits, which holds 32 new bits plus up to 8 residual bits.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  code word present
- in_ready  out  1  block can accept a code word this cycle
- in_val  in  32  code value, right-justified; bits above in_n are ignored (masked)
- in_n  in  6  number of bits to write, 0–32; values 33–63 are clamped to 32
- flush_req  in  1  request byte alignment and full drain
- flush_done  out  1  one-cycle pulse when a flush has fully drained
- out_byte  out  8  next stream byte, equal to acc[39:32]
- out_valid  out  1  out_byte is valid
- out_ready  in  1  downstream accepts the byte
- total_bits  out  32  bits written since reset, including pad bits; wraps modulo 2^32

## Operation
- **State:**
  - acc[39:0]: valid bits are left-aligned at acc[39 : 40-fill].
  - fill[5:0]: number of valid bits, 0–40.
  - st: one of RUN or FLUSH.
  - Invariant: acc bits below the valid region are always 0.
- **Outputs:**
  - in_ready = (st==RUN) && (fill <= 8), decoded from registered state only.
  - out_valid = (fill >= 8).
- **Drain:** when out_valid && out_ready, the accumulator shifts left by 8 and fill decreases by 8.
- **Insert:** when in_valid && in_ready, let v = in_val & mask(in_n) and let f' = fill after any same-cycle drain.
  - acc becomes (acc after drain) | (v << (40 - f' - in_n)).
  - fill becomes f' + in_n.
  - total_bits increases by in_n.
  - in_n = 0 is a legal no-op that still completes the handshake.
- **Drain and insert in the same cycle** are both applied, drain first. This sustains 1 byte/cycle.
- **Flush entry:** flush_req is sampled only in RUN.
  - If a code word is also accepted in that cycle, the code word is packed first.
  - fill is then rounded up to a multiple of 8. The pad bits are zeros, which the invariant already guarantees.
  - total_bits increases by the pad amount (0–7).
  - st moves to FLUSH.
- **FLUSH:** in_ready = 0. Bytes drain normally.
  - In the cycle where fill reaches 0, flush_done pulses for one cycle on the following edge and st returns to RUN.
  - If fill is already 0 at entry, flush_done pulses on the next cycle.
- flush_req is ignored while in FLUSH.
- **Reset values:** acc = 0, fill = 0, st = RUN, total_bits = 0, out_valid = 0, in_ready = 1, flush_done = 0.
- **Reset mid-stream** discards all pending bits and any flush in progress, with no partial byte emitted.

## Timing
- All state is registered. There is no combinational path from in_valid or in_val to out_byte or out_valid.
- Latency: a word accepted at edge k that brings fill to 8 or more makes out_valid high in cycle k+1.
- Throughput:
  - One byte per cycle while out_ready is held high.
  - 32-bit words sustain one word every 4 cycles.
  - Short codes are accepted on every cycle while fill <= 8.
- in_ready depends only on registered fill and st, never on out_ready in the same cycle. Its worst case is therefore one cycle conservative.
- out_byte and out_valid stay stable while out_ready = 0.
- flush_done is high for exactly one cycle per accepted flush_req.

## Test plan
1. Reset, then idle → out_valid=0, in_ready=1, flush_done=0, total_bits=0.
2. Write in_val=0x000001B3, in_n=32 with out_ready=1 → bytes 0x00, 0x00, 0x01, 0xB3 on four consecutive cycles starting one cycle after accept; total_bits=32.
3. Write (0b101, 3) then (0b00110, 5) → single byte 0xA6; neither write stalls.
4. Write (0xFFFFFFF5, 4) then (0x0, 4) → byte 0x50, which confirms upper-bit masking. Then write (0x3, 0) → no byte and total_bits unchanged at 8.
5. Write (0x1, 1), then assert flush_req → byte 0x80, then flush_done pulses once the following cycle; total_bits=8; in_ready=0 while flushing.
6. Hold out_ready=0 and write two words 0xDEADBEEF/32 and 0x01234567/32 → first accepted, in_ready=0. Release out_ready → second accepted after three bytes drain (fill=8); output is DE AD BE EF 01 23 45 67 in order. Assert rst mid-drain → out_valid=0 the next cycle.

Source files
------------

// File: rtl/putbits_packer.sv
// MSB-first bitstream writer: packs 0-32 bit codes into a 40-bit accumulator, emits bytes.
// Latency: byte valid the cycle after the accepting edge; backpressure via in_ready (fill<=8) and out_ready.
module putbits_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_val,
  input  logic [5:0]  in_n,
  input  logic        flush_req,
  output logic        flush_done,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] total_bits
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      st;
  logic [39:0] acc;
  logic [5:0]  fill;

  logic        drain, accept;
  logic [5:0]  n_clamp, pad, shamt;
  logic [31:0] v;
  logic [39:0] acc_d, acc_n;
  logic [5:0]  fill_d, fill_ins, fill_n;

  assign in_ready  = (st == RUN) && (fill <= 6'd8);
  assign out_valid = (fill >= 6'd8);
  assign out_byte  = acc[39:32];

  assign drain  = out_valid && out_ready;
  assign accept = in_valid && in_ready;

  always_comb begin
    n_clamp = 6'd0;
    v       = 32'd0;
    shamt   = 6'd0;
    acc_d   = drain ? {acc[31:0], 8'd0} : acc;
    fill_d  = drain ? fill - 6'd8 : fill;
    acc_n   = acc_d;
    fill_ins = fill_d;
    if (accept) begin
      n_clamp = (in_n > 6'd32) ? 6'd32 : in_n;
      v = (n_clamp == 6'd32) ? in_val : (in_val & ((32'd1 << n_clamp) - 32'd1));
      // accept only when fill_d <= 8, so the shift stays within 0..40
      shamt    = 6'd40 - fill_d - n_clamp;
      acc_n    = acc_d | ({8'd0, v} << shamt);
      fill_ins = fill_d + n_clamp;
    end
    pad    = (6'd8 - {3'd0, fill_ins[2:0]}) & 6'd7;
    fill_n = fill_ins;
    if (st == RUN && flush_req) fill_n = fill_ins + pad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= 40'd0;
      fill       <= 6'd0;
      st         <= RUN;
      total_bits <= 32'd0;
      flush_done <= 1'b0;
    end else begin
      acc        <= acc_n;
      fill       <= fill_n;
      flush_done <= 1'b0;
      if (st == RUN) begin
        if (flush_req) begin
          total_bits <= total_bits + {26'd0, n_clamp} + {26'd0, pad};
          // nothing left to drain: complete immediately
          if (fill_n == 6'd0) flush_done <= 1'b1;
          else                st         <= FLUSH;
        end else begin
          total_bits <= total_bits + {26'd0, n_clamp};
        end
      end else if (fill_n == 6'd0) begin
        flush_done <= 1'b1;
        st         <= RUN;
      end
    end
  end

endmodule
